// File: rtl/sram_stream_loader.sv
// Byte-stream to SRAM word loader: packs bytes little-endian into 4-lane words
// and issues one byte-masked SRAM write per (possibly partial) word.
module sram_stream_loader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              SRAM_CS,
  output logic              SRAM_OE,
  output logic [3:0]        SRAM_WEB,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [DATA_W-1:0] SRAM_DI,
  output logic              busy,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam int NUM_LANES = DATA_W / 8;
  localparam int LANE_W    = $clog2(NUM_LANES);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                      state, state_nxt;
  logic [ADDR_W-1:0]           addr;
  logic [LANE_W-1:0]           lane;
  logic [NUM_LANES-1:0]        filled, filled_nxt;
  logic [NUM_LANES-1:0][7:0]   word_q, word_nxt;
  logic                        last_q;
  logic                        acc, word_end;

  assign acc      = (state == FILL) && in_valid;
  assign word_end = acc && ((lane == LANE_W'(NUM_LANES-1)) || in_last);

  // Per-lane byte insert; unaccepted lanes keep their (cleared) contents.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic hit;
    assign hit           = acc && (lane == LANE_W'(k));
    assign word_nxt[k]   = hit ? in_data : word_q[k];
    assign filled_nxt[k] = hit | filled[k];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_start) state_nxt = FILL;
      FILL:    if (word_end)   state_nxt = WRITE;
      WRITE:   state_nxt = last_q ? DONE : FILL;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr       <= '0;
      lane       <= '0;
      filled     <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
      SRAM_A     <= '0;
      SRAM_DI    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && load_start) begin
        addr       <= load_base;
        word_count <= '0;
        overflow   <= 1'b0;
        lane       <= '0;
        filled     <= '0;
        word_q     <= '0;
        last_q     <= 1'b0;
      end
      // Address/data are registered on the closing byte so they are stable
      // throughout WRITE and then simply hold.
      if (acc) begin
        word_q <= word_nxt;
        filled <= filled_nxt;
        lane   <= lane + LANE_W'(1);
        if (word_end) begin
          last_q  <= in_last;
          SRAM_A  <= addr;
          SRAM_DI <= word_nxt;
        end
      end
      if (state == WRITE) begin
        addr       <= addr + ADDR_W'(1);
        word_count <= word_count + (ADDR_W+1)'(1);
        if (&addr) overflow <= 1'b1;
        lane   <= '0;
        filled <= '0;
        word_q <= '0;
      end
    end
  end

  assign in_ready  = (state == FILL);
  assign SRAM_CS   = (state == WRITE);
  assign SRAM_OE   = 1'b0;
  assign SRAM_WEB  = SRAM_CS ? ~filled : '1;
  assign busy      = (state != IDLE);
  assign load_done = (state == DONE);

endmodule

// File: tb/tb_sram_stream_loader.sv
// Directed bench for sram_stream_loader: hand-computed SRAM writes, latency,
// overflow, gapped input, reset abort and mid-load start rejection.
module tb_sram_stream_loader;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  logic              clk = 1'b0, rst = 1'b1;
  logic              load_start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [ADDR_W-1:0] load_base = '0;
  logic [7:0]        in_data = '0;
  logic              in_ready, SRAM_CS, SRAM_OE, busy, load_done, overflow;
  logic [3:0]        SRAM_WEB;
  logic [ADDR_W-1:0] SRAM_A;
  logic [DATA_W-1:0] SRAM_DI;
  logic [ADDR_W:0]   word_count;

  int ntests = 0, nfail = 0, done_cnt = 0, rdy_in_wr = 0;
  logic [ADDR_W-1:0] wa[$];
  logic [DATA_W-1:0] wd[$];
  logic [3:0]        ww[$];

  sram_stream_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .SRAM_CS(SRAM_CS), .SRAM_OE(SRAM_OE), .SRAM_WEB(SRAM_WEB), .SRAM_A(SRAM_A),
    .SRAM_DI(SRAM_DI), .busy(busy), .load_done(load_done), .overflow(overflow),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (SRAM_CS) begin
      wa.push_back(SRAM_A);
      wd.push_back(SRAM_DI);
      ww.push_back(SRAM_WEB);
      if (in_ready) rdy_in_wr++;
    end
    if (load_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_log();
    wa.delete(); wd.delete(); ww.delete();
  endtask

  task automatic start(input logic [ADDR_W-1:0] base);
    load_base = base; load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit last, input bit gap);
    int n = 0;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("rdy_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Called right after the last byte is accepted: WRITE now, DONE next, then IDLE.
  task automatic finish_load(input string tag, input int exp_wc);
    chk({tag, "_cs"}, SRAM_CS, 1);
    chk({tag, "_rdy_wr"}, in_ready, 0);
    @(posedge clk); #1;
    chk({tag, "_done"}, load_done, 1);
    chk({tag, "_wc"}, word_count, exp_wc);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, load_done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [3:0] w);
    if (i < wa.size()) begin
      chk({tag, "_a"}, wa[i], a);
      chk({tag, "_di"}, wd[i], d);
      chk({tag, "_web"}, ww[i], w);
    end else chk({tag, "_missing"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    #2 rst = 1'b0;
    #10;
    chk("rst_cs", SRAM_CS, 0);
    chk("rst_web", SRAM_WEB, 4'hF);
    chk("rst_oe", SRAM_OE, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_wc", word_count, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // One full word, last on lane 3
    clr_log();
    start(14'h0010);
    chk("s1_busy", busy, 1);
    send(8'h11, 0, 0); send(8'h22, 0, 0); send(8'h33, 0, 0); send(8'h44, 1, 0);
    finish_load("s1", 1);
    chk("s1_nwr", wa.size(), 1);
    chk_wr("s1_w0", 0, 14'h0010, 32'h44332211, 4'b0000);

    // Six bytes: full word then partial
    clr_log();
    start(14'h0000);
    for (int i = 1; i <= 6; i++) send(8'(i), i == 6, 0);
    finish_load("s2", 2);
    chk("s2_nwr", wa.size(), 2);
    chk_wr("s2_w0", 0, 14'h0000, 32'h04030201, 4'b0000);
    chk_wr("s2_w1", 1, 14'h0001, 32'h00000605, 4'b1100);

    // Address wrap
    clr_log();
    start(14'h3FFF);
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), i == 7, 0);
    finish_load("s3", 2);
    chk_wr("s3_w0", 0, 14'h3FFF, 32'h13121110, 4'b0000);
    chk_wr("s3_w1", 1, 14'h0000, 32'h17161514, 4'b0000);
    chk("s3_ovf", overflow, 1);

    // Gapped input
    clr_log();
    rdy_in_wr = 0;
    start(14'h0020);
    chk("s4_ovf_clr", overflow, 0);
    for (int i = 0; i < 5; i++) send(8'hA1 + 8'(i), i == 4, i != 0);
    finish_load("s4", 2);
    chk_wr("s4_w0", 0, 14'h0020, 32'hA4A3A2A1, 4'b0000);
    chk_wr("s4_w1", 1, 14'h0021, 32'h000000A5, 4'b1110);
    chk("s4_rdy_in_write", rdy_in_wr, 0);

    // Reset abort during FILL
    clr_log();
    dc = done_cnt;
    start(14'h0050);
    send(8'h61, 0, 0); send(8'h62, 0, 0);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("s5_cs", SRAM_CS, 0);
    chk("s5_web", SRAM_WEB, 4'hF);
    chk("s5_a", SRAM_A, 0);
    chk("s5_di", SRAM_DI, 0);
    chk("s5_busy", busy, 0);
    chk("s5_rdy", in_ready, 0);
    chk("s5_wc", word_count, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("s5_nwr", wa.size(), 0);
    chk("s5_nodone", done_cnt, dc);
    start(14'h0007);
    send(8'hC1, 0, 0); send(8'hC2, 0, 0); send(8'hC3, 0, 0); send(8'hC4, 1, 0);
    finish_load("s5b", 1);
    chk_wr("s5b_w0", 0, 14'h0007, 32'hC4C3C2C1, 4'b0000);

    // load_start mid-load is ignored
    clr_log();
    start(14'h0200);
    send(8'h51, 0, 0); send(8'h52, 0, 0);
    load_base = 14'h0100; load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0; load_base = '0;
    chk("s6_busy", busy, 1);
    for (int i = 3; i <= 6; i++) send(8'h50 + 8'(i), i == 6, 0);
    finish_load("s6", 2);
    chk_wr("s6_w0", 0, 14'h0200, 32'h54535251, 4'b0000);
    chk_wr("s6_w1", 1, 14'h0201, 32'h00005655, 4'b1100);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
